cifra_bloco_iterativa: RTL

//  Iterative AES-128 encryption engine, one round per clock. Wraps the combinational round core

---
 rtl/cifra_bloco_iterativa_pkg.sv | 71 +++++++
 rtl/cifra_bloco_iterativa_expande.sv | 43 ++++
 rtl/cifra_bloco_iterativa_miolo.sv | 67 ++++++
 rtl/cifra_bloco_iterativa.sv | 95 +++++++++
 4 files changed

// File: rtl/cifra_bloco_iterativa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cifra_bloco_iterativa_pkg
//  Description : Shared AES-128 definitions: widths, round count, FSM state
//                encoding, S-box table and the byte/word helpers used by the
//                key expander and the round core.
//  Revision    : 1.0 - initial release
// ============================================================================
package cifra_bloco_iterativa_pkg;

  localparam int AES_BLOCO_W      = 128;
  localparam int AES_CHAVE_W      = 128;
  localparam int AES_CHAVE_EXP_W  = 1280;
  localparam int AES_NUM_RODADAS  = 10;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RODADAS = 2'd1,
    FIM     = 2'd2
  } estado_t;

  // Forward S-box, indexed by the input byte.
  localparam logic [7:0] c_sbox [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants for key-schedule words 4,8,...,40 (first byte = round 1).
  localparam logic [79:0] c_rcon = 80'h01020408102040801b36;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box applied to each byte of a 32-bit word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {c_sbox[w[31:24]], c_sbox[w[23:16]], c_sbox[w[15:8]], c_sbox[w[7:0]]};
  endfunction

  // MixColumns on one column; byte a0 is the top row (MSB).
  function automatic logic [31:0] mistura_coluna(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cifra_bloco_iterativa_expande.sv
`default_nettype none
// ============================================================================
//  Module      : expandeChave
//  Description : Combinational AES-128 key schedule. Produces round keys
//                1..10; round key k sits at o_chave_expandida[128*(k-1) +: 128].
//                Round key 0 is the cipher key itself and is not repeated.
//  Revision    : 1.0 - initial release
// ============================================================================
module expandeChave
  import cifra_bloco_iterativa_pkg::*;
(
  input  logic [AES_CHAVE_W-1:0]     i_chave,
  output logic [AES_CHAVE_EXP_W-1:0] o_chave_expandida
);

  // Word j of the schedule lives at w[32*j +: 32]; 44 words for AES-128.
  function automatic logic [AES_CHAVE_EXP_W-1:0] expande(input logic [AES_CHAVE_W-1:0] k);
    logic [44*32-1:0]            w;
    logic [31:0]                 t;
    logic [AES_CHAVE_EXP_W-1:0]  r;
    w = '0;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      w[32*j +: 32] = k[127-32*j -: 32];
    end
    for (int j = 4; j < 44; j++) begin
      t = w[32*(j-1) +: 32];
      if (j % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {c_rcon[79-8*(j/4-1) -: 8], 24'h000000};
      end
      w[32*j +: 32] = w[32*(j-4) +: 32] ^ t;
    end
    for (int rk = 1; rk <= AES_NUM_RODADAS; rk++) begin
      r[128*(rk-1) +: 128] = {w[32*(4*rk) +: 32], w[32*(4*rk+1) +: 32],
                              w[32*(4*rk+2) +: 32], w[32*(4*rk+3) +: 32]};
    end
    return r;
  endfunction

  assign o_chave_expandida = expande(i_chave);

endmodule
`default_nettype wire

// File: rtl/cifra_bloco_iterativa_miolo.sv
`default_nettype none
// ============================================================================
//  Module      : mioloCifraBloco
//  Description : Combinational AES round: SubBytes, ShiftRows, MixColumns
//                (skipped on the final round) and AddRoundKey with the round
//                key chosen by i_rodada from the expanded key.
//  Revision    : 1.0 - initial release
// ============================================================================
module mioloCifraBloco
  import cifra_bloco_iterativa_pkg::*;
(
  input  logic [AES_BLOCO_W-1:0]     i_estado,
  input  logic [AES_CHAVE_EXP_W-1:0] i_chave_expandida,
  input  logic [3:0]                 i_rodada,
  output logic [AES_BLOCO_W-1:0]     o_estado
);

  logic [AES_BLOCO_W-1:0] w_chave_rodada;
  logic                   w_ultima;

  // Byte b of the state (b = row + 4*col) is s[127-8*b -: 8].
  function automatic logic [AES_BLOCO_W-1:0] rodada_aes(
    input logic [AES_BLOCO_W-1:0] s,
    input logic [AES_BLOCO_W-1:0] rk,
    input logic                   ultima
  );
    logic [AES_BLOCO_W-1:0] sub;
    logic [AES_BLOCO_W-1:0] desl;
    logic [AES_BLOCO_W-1:0] res;
    logic [31:0]            col;
    sub  = '0;
    desl = '0;
    res  = '0;
    for (int b = 0; b < 16; b++) begin
      sub[127-8*b -: 8] = c_sbox[s[127-8*b -: 8]];
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        desl[127-8*(r+4*c) -: 8] = sub[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      col = desl[127-32*c -: 32];
      if (!ultima) begin
        col = mistura_coluna(col);
      end
      res[127-32*c -: 32] = col;
    end
    return res ^ rk;
  endfunction

  // Round-key mux; an out-of-range round selects zero rather than wrapping.
  always_comb begin
    w_chave_rodada = '0;
    for (int i = 1; i <= AES_NUM_RODADAS; i++) begin
      if (i_rodada == 4'(i)) begin
        w_chave_rodada = i_chave_expandida[128*(i-1) +: 128];
      end
    end
  end

  assign w_ultima = (i_rodada == 4'(AES_NUM_RODADAS));
  assign o_estado = rodada_aes(i_estado, w_chave_rodada, w_ultima);

endmodule
`default_nettype wire

// File: rtl/cifra_bloco_iterativa.sv
`default_nettype none
// ============================================================================
//  Module      : cifra_bloco_iterativa
//  Description : Iterative AES-128 encryptor, one round per clock. Latches
//                block and key on start, applies the initial AddRoundKey, runs
//                rounds 1..10 through the shared round core and presents the
//                ciphertext with a one-cycle valido pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module cifra_bloco_iterativa
  import cifra_bloco_iterativa_pkg::*;
#(
  parameter int NUM_RODADAS = AES_NUM_RODADAS
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [AES_BLOCO_W-1:0] bloco,
  input  logic [AES_CHAVE_W-1:0] chave,
  output logic                   pronto,
  output logic                   valido,
  output logic [AES_BLOCO_W-1:0] saida
);

  localparam logic [3:0] c_ultima = 4'(NUM_RODADAS);

  estado_t                    r_fsm;
  logic [3:0]                 r_rodada;
  logic [AES_BLOCO_W-1:0]     r_estado;
  logic [AES_CHAVE_W-1:0]     r_chave;
  logic [AES_CHAVE_EXP_W-1:0] w_chave_exp;
  logic [AES_BLOCO_W-1:0]     w_miolo;

  // Key schedule runs from the latched key so input changes mid-run are harmless.
  expandeChave u_expande (
    .i_chave           (r_chave),
    .o_chave_expandida (w_chave_exp)
  );

  mioloCifraBloco u_miolo (
    .i_estado          (r_estado),
    .i_chave_expandida (w_chave_exp),
    .i_rodada          (r_rodada),
    .o_estado          (w_miolo)
  );

  // Control FSM, round counter, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm    <= OCIOSO;
      r_rodada <= 4'd0;
      r_estado <= '0;
      r_chave  <= '0;
      pronto   <= 1'b1;
      valido   <= 1'b0;
      saida    <= '0;
    end else begin
      case (r_fsm)
        OCIOSO: begin
          if (inicio && pronto) begin
            r_estado <= bloco ^ chave;
            r_chave  <= chave;
            r_rodada <= 4'd1;
            pronto   <= 1'b0;
            r_fsm    <= RODADAS;
          end
        end
        RODADAS: begin
          r_estado <= w_miolo;
          if (r_rodada == c_ultima) begin
            saida    <= w_miolo;
            valido   <= 1'b1;
            r_rodada <= 4'd0;
            r_fsm    <= FIM;
          end else begin
            r_rodada <= r_rodada + 4'd1;
          end
        end
        FIM: begin
          valido <= 1'b0;
          pronto <= 1'b1;
          r_fsm  <= OCIOSO;
        end
        default: begin
          r_fsm    <= OCIOSO;
          r_rodada <= 4'd0;
          valido   <= 1'b0;
          pronto   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
